map_port_arbiter: RTL
=====================

# map_port_arbiter

Shares the single-port 32x36 tile map RAM between the video renderer and the game-logic requesters (pacman movement, ghost AI, pellet clear). Video reads have fixed top priority and fixed one-cycle latency, so the display pipeline never stalls. Game requesters get the RAM in idle cycles under round-robin arbitration with a req/gnt handshake. The block sits between the tile RAM instance and every map consumer inside the game top level.

## Interface
- `N_REQ`, 3: number of game-logic requesters.
- `ADDR_W`, 11: map word address width.
- `DATA_W`, 4: tile code width.
- `DEPTH`, 1152: valid map words (32*36); addresses >= DEPTH are out of range.
- `vga_pix_clk` in 1: the single clock; every register samples on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `vid_req` in 1: video read request for this cycle.
- `vid_addr` in ADDR_W: video read address.
- `vid_rdata` out DATA_W: video read data.
- `vid_rvalid` out 1: `vid_rdata` is valid.
- `gm_req` in N_REQ: per-requester request; held until granted.
- `gm_we` in N_REQ: per-requester write enable (1 = write, 0 = read).
- `gm_addr` in N_REQ*ADDR_W: packed addresses; requester i uses slice i.
- `gm_wdata` in N_REQ*DATA_W: packed write data.
- `gm_gnt` out N_REQ: one-hot grant pulse.
- `gm_rdata` out DATA_W: shared game read data.
- `gm_rvalid` out N_REQ: one-hot read-data-valid pulse.
- `vid_blank` in 1: high outside the visible area. Used only under `MAP_ARB_WRITE_GUARD_EN`.
- `ram_en`, `ram_we` out 1: RAM port controls.
- `ram_addr` out ADDR_W: RAM address.
- `ram_wdata` out DATA_W: RAM write data.
- `ram_rdata` in DATA_W: RAM read data, synchronous, valid one cycle after `ram_en`.

## Operation
- Each cycle, one access is issued, chosen in priority order:
  1. `vid_req`.
  2. Otherwise, the eligible `gm_req` bit found first when searching upward from `rr_ptr`, with modular wrap.
- Grant selection is combinational: `gm_gnt` can assert in the first cycle `gm_req` is seen. `ram_*` are driven in that same cycle.
- A requester holds `gm_addr`, `gm_we` and `gm_wdata` stable until its `gm_gnt` pulse. Each grant serves exactly one access. If `gm_req` is still high after a grant, it is a new request.
- `rr_ptr` is a `$clog2(N_REQ)`-bit register.
  - After a grant to requester i, `rr_ptr` becomes (i+1) mod N_REQ.
  - It is unchanged in video or idle cycles.
- Dropping `gm_req` before the grant withdraws the request without side effect.
- Out-of-range address (>= DEPTH):
  - `ram_en` stays 0.
  - The access is still granted or acknowledged.
  - A read returns 0; a write is discarded.
- Response tracking uses a registered tag `{valid, is_vid, idx, oor}` captured at issue.
  - `vid_rvalid` and `vid_rdata` are driven from that tag in the cycle after issue.
  - `gm_rvalid[idx]` and `gm_rdata` are driven likewise.
  - Writes produce no `gm_rvalid`.
- `gm_rdata` and `vid_rdata` are 0 whenever their valid is low.
- A game write and a video read of the same address cannot be issued in the same cycle. Ordering is strict issue order: a read issued after a write sees the new value.

## Timing
- Reset, asynchronous: tag valid = 0 and `rr_ptr` = 0. While `rst` is high, all outputs are 0, including the combinational `gm_gnt` and `ram_*`.
- A response in flight when reset asserts is dropped. No `rvalid` follows reset deassertion.
- Read latency is exactly 1 cycle from the issue/grant cycle to `rvalid`, for both video and game ports.
- Throughput is one access per cycle. Back-to-back grants to different requesters are allowed.
- Video starvation of game requesters is unbounded by design. Video demand is one read per 8 pixels, so gaps are guaranteed in practice.
- If `vid_req` and all `gm_req` are high at once: video is served, and no `gm_gnt` or `rr_ptr` change happens that cycle.

## Configuration
- `MAP_ARB_WRITE_GUARD_EN`:
  - Defined: a game write request is eligible only while `vid_blank` = 1. Game reads are always eligible. An ineligible write does not block a lower-order read from being granted, and `rr_ptr` skips it normally.
  - Undefined: `vid_blank` is ignored, and writes are eligible in any idle cycle.

## Test plan
- Reset mid-read: issue a video read of addr 5, then assert `rst` the next cycle -> `vid_rvalid` = 0 during and after reset, `rr_ptr` = 0.
- Video priority: `vid_req`=1 at addr 33 together with `gm_req`=3'b111 -> `ram_addr`=33 and `gm_gnt`=0. In the next cycle `vid_rvalid`=1 with `vid_rdata`=RAM[33].
- Round robin: `gm_req`=3'b111 held, with `vid_req`=0 -> grants 001, 010, 100, 001 on consecutive cycles. Each read returns `gm_rvalid` one-hot one cycle later.
- Write then read: requester 1 writes 4'hA to addr 100, then requester 2 reads addr 100 -> `gm_rvalid`=3'b100 with `gm_rdata`=4'hA.
- Out of range: requester 0 reads addr 1200 -> granted, `ram_en`=0, `gm_rdata`=0 with `gm_rvalid`=3'b001 the next cycle. A write to addr 1200 leaves the RAM unchanged.
- Write guard (macro defined):
  - Requester 0 write pending and requester 1 read pending, `vid_blank`=0 -> only requester 1 is granted.
  - After `vid_blank` goes to 1 -> requester 0's write is granted in the next idle cycle.

Source files
------------

// File: rtl/map_port_arbiter_if.sv
// Bus bundle between map_port_arbiter, its video/game clients and the tile-map RAM.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface map_port_arbiter_if #(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = 11,
  parameter int DATA_W = 4
);
  logic                      vid_req;
  logic [ADDR_W-1:0]         vid_addr;
  logic [DATA_W-1:0]         vid_rdata;
  logic                      vid_rvalid;
  logic                      vid_blank;
  logic [N_REQ-1:0]          gm_req;
  logic [N_REQ-1:0]          gm_we;
  logic [N_REQ*ADDR_W-1:0]   gm_addr;
  logic [N_REQ*DATA_W-1:0]   gm_wdata;
  logic [N_REQ-1:0]          gm_gnt;
  logic [DATA_W-1:0]         gm_rdata;
  logic [N_REQ-1:0]          gm_rvalid;
  logic                      ram_en;
  logic                      ram_we;
  logic [ADDR_W-1:0]         ram_addr;
  logic [DATA_W-1:0]         ram_wdata;
  logic [DATA_W-1:0]         ram_rdata;

  modport slave (
    input  vid_req, vid_addr, vid_blank, gm_req, gm_we, gm_addr, gm_wdata, ram_rdata,
    output vid_rdata, vid_rvalid, gm_gnt, gm_rdata, gm_rvalid,
    output ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output vid_req, vid_addr, vid_blank, gm_req, gm_we, gm_addr, gm_wdata, ram_rdata,
    input  vid_rdata, vid_rvalid, gm_gnt, gm_rdata, gm_rvalid,
    input  ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/map_port_arbiter.sv
// Tile-map RAM port arbiter: video reads always win, game requesters share idle cycles round-robin.
// Optional feature macro MAP_ARB_WRITE_GUARD_EN: game writes are only eligible while vid_blank is high.
module map_port_arbiter #(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = 11,
  parameter int DATA_W = 4,
  parameter int DEPTH  = 1152
) (
  input  logic              vga_pix_clk,
  input  logic              rst,
  map_port_arbiter_if.slave bus
);
  localparam int               IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              tag_valid_q, tag_valid_d;
  logic              tag_vid_q, tag_vid_d;
  logic [IDX_W-1:0]  tag_idx_q, tag_idx_d;
  logic              tag_oor_q, tag_oor_d;

  logic [N_REQ-1:0]  elig_s;
  logic              gm_hit_s;
  logic [IDX_W-1:0]  gm_idx_s;
  logic              vid_issue_s;
  logic              gm_issue_s;
  logic              any_issue_s;
  logic              wr_issue_s;
  logic              oor_s;
  logic [ADDR_W-1:0] addr_s;
  logic [DATA_W-1:0] wdata_s;
  logic [DATA_W-1:0] rsp_data_s;

`ifdef MAP_ARB_WRITE_GUARD_EN
  // Writes only become candidates during blanking; reads are always candidates.
  always_comb begin
    elig_s = bus.gm_req & ~(bus.gm_we & {N_REQ{~bus.vid_blank}});
  end
`else
  logic guard_unused_s;
  assign guard_unused_s = bus.vid_blank;

  always_comb begin
    elig_s = bus.gm_req;
  end
`endif

  // Round-robin search: first pass from rr_ptr upward, second pass wraps from index 0.
  always_comb begin
    gm_hit_s = 1'b0;
    gm_idx_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!gm_hit_s && elig_s[i] && (IDX_W'(i) >= rr_ptr_q)) begin
        gm_hit_s = 1'b1;
        gm_idx_s = IDX_W'(i);
      end else begin
        gm_hit_s = gm_hit_s;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!gm_hit_s && elig_s[i]) begin
        gm_hit_s = 1'b1;
        gm_idx_s = IDX_W'(i);
      end else begin
        gm_hit_s = gm_hit_s;
      end
    end
  end

  always_comb begin
    vid_issue_s = bus.vid_req;
    gm_issue_s  = ~bus.vid_req & gm_hit_s;
    any_issue_s = vid_issue_s | gm_issue_s;
    addr_s      = bus.vid_req ? bus.vid_addr
                              : bus.gm_addr[int'(gm_idx_s) * ADDR_W +: ADDR_W];
    wdata_s     = bus.gm_wdata[int'(gm_idx_s) * DATA_W +: DATA_W];
    wr_issue_s  = gm_issue_s & bus.gm_we[gm_idx_s];
    oor_s       = ({1'b0, addr_s} >= DEPTH_L);
  end

  // RAM port and grant pulse; everything is forced low while reset is held.
  always_comb begin
    bus.ram_en    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    bus.gm_gnt    = '0;
    if (rst) begin
      bus.ram_en = 1'b0;
    end else begin
      bus.ram_en    = any_issue_s & ~oor_s;
      bus.ram_we    = any_issue_s & ~oor_s & wr_issue_s;
      bus.ram_addr  = any_issue_s ? addr_s : '0;
      bus.ram_wdata = wr_issue_s ? wdata_s : '0;
      for (int i = 0; i < N_REQ; i++) begin
        bus.gm_gnt[i] = gm_issue_s & (gm_idx_s == IDX_W'(i));
      end
    end
  end

  // Response tag and round-robin pointer next state; writes leave no tag behind.
  always_comb begin
    tag_valid_d = vid_issue_s | (gm_issue_s & ~wr_issue_s);
    tag_vid_d   = vid_issue_s;
    tag_idx_d   = vid_issue_s ? '0 : gm_idx_s;
    tag_oor_d   = oor_s;
    if (gm_issue_s) begin
      rr_ptr_d = (gm_idx_s == LAST_IDX) ? '0 : gm_idx_s + IDX_W'(1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  always_ff @(posedge vga_pix_clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      tag_valid_q <= 1'b0;
      tag_vid_q   <= 1'b0;
      tag_idx_q   <= '0;
      tag_oor_q   <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      tag_valid_q <= tag_valid_d;
      tag_vid_q   <= tag_vid_d;
      tag_idx_q   <= tag_idx_d;
      tag_oor_q   <= tag_oor_d;
    end
  end

  // Out-of-range reads never touched the RAM, so their data is substituted with zero.
  always_comb begin
    rsp_data_s     = tag_oor_q ? '0 : bus.ram_rdata;
    bus.vid_rvalid = tag_valid_q & tag_vid_q;
    bus.vid_rdata  = (tag_valid_q & tag_vid_q) ? rsp_data_s : '0;
    bus.gm_rdata   = (tag_valid_q & ~tag_vid_q) ? rsp_data_s : '0;
    for (int i = 0; i < N_REQ; i++) begin
      bus.gm_rvalid[i] = tag_valid_q & ~tag_vid_q & (tag_idx_q == IDX_W'(i));
    end
  end
endmodule
